// File: rtl/csd2bin_pipe.sv
// Pipelined borrow-save (x_d - x_s) to two's-complement converter with an overflow flag.
// The carry chain is cut into S registered segments with valid/ready flow control.
module csd2bin_pipe #(
  parameter int W = 64,
  parameter int S = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] x,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   y,
  output logic           ovf,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int C  = (S > 0) ? W / S : 1;
  localparam int XQ = (S > 1) ? S - 1 : 1;

  if (S < 1 || S > W || (W % S) != 0) begin : g_bad_params
    $error("csd2bin_pipe: S must lie in 1..W and divide W evenly");
  end

  logic [S-1:0]   v_q;
  logic [S-1:0]   v_in;
  logic [S-1:0]   adv;
  // Segment carry-out per stage; the last stage keeps ovf in this slot instead.
  logic [S-1:0]   c_q;
  logic [S-1:0]   c_in;
  logic [S-1:0]   st_nxt;
  logic [W-1:0]   y_q   [S];
  logic [W-1:0]   y_in  [S];
  logic [W-1:0]   y_nxt [S];
  logic [2*W-1:0] x_q   [XQ];
  logic [2*W-1:0] sx    [S];
  logic           rc;

  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = 1'b1;
    y_in[0] = '0;
    sx[0]   = x;
    for (int k = 1; k < S; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      y_in[k] = y_q[k-1];
      sx[k]   = x_q[k-1];
    end
  end

  // Each digit adds x_d + ~x_s + carry, so digit 11 behaves exactly like 00.
  always_comb begin
    rc = 1'b0;
    for (int k = 0; k < S; k++) begin
      rc       = c_in[k];
      y_nxt[k] = y_in[k];
      for (int j = 0; j < C; j++) begin
        y_nxt[k][k*C+j] = sx[k][2*(k*C+j)] ^ ~sx[k][2*(k*C+j)+1] ^ rc;
        rc = (sx[k][2*(k*C+j)] & ~sx[k][2*(k*C+j)+1]) |
             (rc & (sx[k][2*(k*C+j)] | ~sx[k][2*(k*C+j)+1]));
      end
      st_nxt[k] = (k == S - 1) ? (~rc ^ y_nxt[k][W-1]) : rc;
    end
  end

  always_comb begin
    adv[S-1] = ~v_q[S-1] | out_ready;
    for (int k = S - 2; k >= 0; k--) begin
      adv[k] = ~v_q[k] | (v_q[k+1] ? adv[k+1] : 1'b1);
    end
  end

  // Stages only load payload when a real word arrives; bubbles just clear v.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < S; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            y_q[k] <= y_nxt[k];
            c_q[k] <= st_nxt[k];
          end
        end
      end
      for (int k = 0; k < S - 1; k++) begin
        if (adv[k] && v_in[k]) begin
          x_q[k] <= sx[k];
        end
      end
    end
  end

  assign in_ready  = adv[0] & ~rst;
  assign y         = y_q[S-1];
  assign ovf       = c_q[S-1];
  assign out_valid = v_q[S-1];

endmodule
